ddfs_poly_mixer: RTL

//  Time-multiplexed N-voice DDFS sine synthesiser with per-voice gain, enable and L/R routing.
//  One shared phase/LUT/multiply pipeline serves all voices; the voice sums are saturated into one stereo frame.

---
 rtl/ddfs_poly_mixer_pkg.sv | 35 +++
 rtl/ddfs_poly_mixer_sine_rom.sv | 29 ++
 rtl/ddfs_poly_mixer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ddfs_poly_mixer_pkg.sv
// Shared types and helpers for the polyphonic DDFS mixer.
// Field widths here are the default parameter widths of the mixer.
package ddfs_poly_pkg;

   localparam int PHASE_W     = 30;
   localparam int GAIN_W      = 16;
   localparam int GAIN_FRAC_D = 14;

   localparam logic signed [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC_D);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

   typedef struct packed {
      logic r;
      logic l;
   } route_t;

   typedef struct packed {
      logic [PHASE_W-1:0]       fccw;
      logic signed [GAIN_W-1:0] gain;
      logic                     en;
      route_t                   route;
   } voice_cfg_t;

   // Clamp to the signed range of a 'bits'-wide sample.
   function automatic logic signed [31:0] sat(input logic signed [31:0] acc, input int bits);
      logic signed [31:0] hi, lo;
      hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (bits - 1));
      if (acc > hi) return hi;
      if (acc < lo) return lo;
      return acc;
   endfunction

endpackage

// File: rtl/ddfs_poly_mixer_sine_rom.sv
// Full-wave sine table with a registered read port.
// Table contents are elaboration-time constants, so it maps to ROM.
module sine_rom #(
   parameter int LUT_ADDR = 10,
   parameter int DATA_BIT = 16
) (
   input  logic                       clk,
   input  logic [LUT_ADDR-1:0]        addr,
   output logic signed [DATA_BIT-1:0] q
);

   localparam int  DEPTH = 1 << LUT_ADDR;
   localparam real AMP   = (2.0 ** (DATA_BIT - 1)) - 1.0;
   localparam real PI    = 3.14159265358979323846;

   logic signed [DATA_BIT-1:0] tab [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_tab
      localparam real S = AMP * $sin(2.0 * PI * k / DEPTH);
      // round half away from zero
      localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
      assign tab[k] = DATA_BIT'(V);
   end

   always_ff @(posedge clk) begin
      q <= tab[addr];
   end

endmodule

// File: rtl/ddfs_poly_mixer.sv
// Time-multiplexed N-voice DDFS synthesiser: one shared phase/ROM/multiply
// pipeline, per-voice gain/enable/routing, saturated stereo frame per tick.
module ddfs_poly_mixer
   import ddfs_poly_pkg::*;
#(
   parameter int  NUM_VOICES  = 4,
   parameter int  PHASE_WIDTH = PHASE_W,
   parameter int  DATA_BIT    = 16,
   parameter int  LUT_ADDR    = 10,
   parameter int  GAIN_FRAC   = GAIN_FRAC_D,
   localparam int VOICE_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_tick,
   input  logic                   i_cfg_we,
   input  logic [VOICE_W-1:0]     i_cfg_voice,
   input  logic [PHASE_WIDTH-1:0] i_cfg_fccw,
   input  logic [15:0]            i_cfg_gain,
   input  logic                   i_cfg_en,
   input  logic [1:0]             i_cfg_route,
   output logic [DATA_BIT-1:0]    o_audio_l,
   output logic [DATA_BIT-1:0]    o_audio_r,
   output logic                   o_audio_valid,
   output logic                   o_busy,
   output logic                   o_overrun
);

   localparam int ACC_W = DATA_BIT + 2 + $clog2(NUM_VOICES);

   state_t                     state, state_nxt;
   voice_cfg_t                 cfg   [NUM_VOICES];
   logic [PHASE_WIDTH-1:0]     phase [NUM_VOICES];
   voice_cfg_t                 cur;
   logic [VOICE_W-1:0]         vidx;
   logic                       issue;
   logic [1:0]                 vld_pipe;
   logic signed [GAIN_W-1:0]   s1_gain;
   logic                       s1_en;
   route_t                     s1_route, s2_route;
   logic signed [DATA_BIT-1:0] rom_q;
   logic signed [DATA_BIT+GAIN_W-1:0] mul;
   logic signed [ACC_W-1:0]    prod, acc_l, acc_r;

   assign cur   = cfg[vidx];
   assign issue = (state == S_RUN);
   assign mul   = rom_q * s1_gain;
   assign o_busy = (state != S_IDLE) || o_audio_valid;

   // ROM is addressed with the pre-increment phase in the issue cycle
   sine_rom #(.LUT_ADDR(LUT_ADDR), .DATA_BIT(DATA_BIT)) u_rom (
      .clk  (i_clk),
      .addr (phase[vidx][PHASE_WIDTH-1 -: LUT_ADDR]),
      .q    (rom_q)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_tick) state_nxt = S_RUN;
         S_RUN:   if (vidx == VOICE_W'(NUM_VOICES - 1)) state_nxt = S_DRAIN;
         // last product lands in the accumulators on the edge leaving DRAIN
         S_DRAIN: if (!vld_pipe[0]) state_nxt = S_OUT;
         S_OUT:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= S_IDLE;
         vidx          <= '0;
         vld_pipe      <= '0;
         s1_gain       <= '0;
         s1_en         <= 1'b0;
         s1_route      <= '0;
         s2_route      <= '0;
         prod          <= '0;
         acc_l         <= '0;
         acc_r         <= '0;
         o_audio_l     <= '0;
         o_audio_r     <= '0;
         o_audio_valid <= 1'b0;
         o_overrun     <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            phase[v] <= '0;
            cfg[v]   <= '{fccw: '0, gain: GAIN_UNITY, en: 1'b0, route: 2'b11};
         end
      end else begin
         state <= state_nxt;
         if (i_tick && state != S_IDLE) o_overrun <= 1'b1;

         if (issue) begin
            vidx <= (vidx == VOICE_W'(NUM_VOICES - 1)) ? '0 : vidx + 1'b1;
            if (cur.en) phase[vidx] <= phase[vidx] + cur.fccw;
         end
         // same-cycle write vs issue: issue above used the old value
         if (i_cfg_we) cfg[i_cfg_voice] <= voice_cfg_t'({i_cfg_fccw, i_cfg_gain, i_cfg_en, i_cfg_route});

         vld_pipe <= {vld_pipe[0], issue};
         s1_gain  <= cur.gain;
         s1_en    <= cur.en;
         s1_route <= cur.route;
         prod     <= s1_en ? ACC_W'(mul >>> GAIN_FRAC) : '0;
         s2_route <= s1_route;

         if (state == S_IDLE && i_tick) begin
            acc_l <= '0;
            acc_r <= '0;
         end else if (vld_pipe[1]) begin
            acc_l <= acc_l + (s2_route.l ? prod : ACC_W'(0));
            acc_r <= acc_r + (s2_route.r ? prod : ACC_W'(0));
         end

         o_audio_valid <= (state == S_OUT);
         if (state == S_OUT) begin
            o_audio_l <= DATA_BIT'(sat(32'(acc_l), DATA_BIT));
            o_audio_r <= DATA_BIT'(sat(32'(acc_r), DATA_BIT));
         end
      end
   end

endmodule
